// File: rtl/video_timing_monitor.sv
// Sink-side video timing monitor: measures HS/VS/BLANK geometry on pixel_clk and reports lock.
// Optional frame checksum port and accumulator exist only when VIDEO_MON_CHECKSUM_EN is defined.
//
//  state   | meaning
//  SEARCH  | no frame reference yet; waiting for a VS fall to start measuring
//  MEASURE | counting consecutive matching frames toward lock
//  LOCKED  | timing matches the expected geometry
module video_timing_monitor #(
    parameter int HDISP       = 800,
    parameter int VDISP       = 480,
    parameter int HTOTAL      = 928,
    parameter int HPULSE      = 48,
    parameter int VTOTAL      = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    input  logic [23:0] rgb,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] meas_htotal,
    output logic [11:0] meas_hpulse,
    output logic [11:0] meas_hactive,
    output logic [10:0] meas_vtotal,
    output logic [10:0] meas_vactive,
    output logic [7:0]  err_count
`ifdef VIDEO_MON_CHECKSUM_EN
    ,
    output logic [31:0] frame_sum
`endif
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [11:0] H_MAX     = '1;
    localparam logic [10:0] V_MAX     = '1;
    localparam logic [11:0] P_HTOTAL  = 12'(HTOTAL);
    localparam logic [11:0] P_HPULSE  = 12'(HPULSE);
    localparam logic [11:0] P_HDISP   = 12'(HDISP);
    localparam logic [10:0] P_VTOTAL  = 11'(VTOTAL);
    localparam logic [10:0] P_VDISP   = 11'(VDISP);
    localparam logic [3:0]  P_LOCK    = 4'(LOCK_FRAMES);
    localparam logic [11:0] LOS_LOAD  = 12'd4095;

    state_t      r_state, w_state_nxt;
    logic        r_hs1, r_hs2, r_vs1, r_vs2, r_blank1;
    logic [11:0] r_h_cnt, r_hp_cnt, r_ha_cnt, r_los_cnt;
    logic [10:0] r_v_cnt, r_va_cnt;
    logic        r_frame_bad, r_los_armed;
    logic [3:0]  r_good, w_good_nxt, w_good_inc;
    logic        w_hs_fall, w_vs_fall, w_line_bad, w_frame_ok, w_los, w_err_inc;
    logic [10:0] w_vtot_close, w_vact_close;

    assign w_hs_fall  = r_hs2 & ~r_hs1;
    assign w_vs_fall  = r_vs2 & ~r_vs1;
    assign w_good_inc = r_good + 4'd1;

    assign w_line_bad = (r_h_cnt != P_HTOTAL) || (r_hp_cnt != P_HPULSE)
                     || ((r_ha_cnt != '0) && (r_ha_cnt != P_HDISP))
                     || (r_h_cnt == H_MAX) || (r_hp_cnt == H_MAX) || (r_ha_cnt == H_MAX);

    // Frame totals as they stand once a coincident HS fall has closed its line
    assign w_vtot_close = (w_hs_fall && r_v_cnt != V_MAX) ? r_v_cnt + 11'd1 : r_v_cnt;
    assign w_vact_close = (w_hs_fall && r_ha_cnt != '0 && r_va_cnt != V_MAX)
                        ? r_va_cnt + 11'd1 : r_va_cnt;

    assign w_frame_ok = !r_frame_bad && !(w_hs_fall && w_line_bad)
                     && (w_vtot_close == P_VTOTAL) && (w_vact_close == P_VDISP)
                     && (w_vtot_close != V_MAX) && (w_vact_close != V_MAX);

    assign w_los = r_los_armed && (r_los_cnt == '0) && !w_hs_fall && (r_state != SEARCH);

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_hs1       <= 1'b0;
            r_hs2       <= 1'b0;
            r_vs1       <= 1'b0;
            r_vs2       <= 1'b0;
            r_blank1    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_hs1       <= hs;
            r_hs2       <= r_hs1;
            r_vs1       <= vs;
            r_vs2       <= r_vs1;
            r_blank1    <= blank;
            line_start  <= w_hs_fall;
            frame_start <= w_vs_fall;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_h_cnt      <= '0;
            r_hp_cnt     <= '0;
            r_ha_cnt     <= '0;
            meas_htotal  <= '0;
            meas_hpulse  <= '0;
            meas_hactive <= '0;
        end else if (w_hs_fall) begin
            meas_htotal  <= r_h_cnt;
            meas_hpulse  <= r_hp_cnt;
            meas_hactive <= r_ha_cnt;
            r_h_cnt      <= 12'd1;
            r_hp_cnt     <= 12'd1;
            r_ha_cnt     <= {11'd0, r_blank1};
        end else begin
            if (r_h_cnt != H_MAX)
                r_h_cnt <= r_h_cnt + 12'd1;
            if (!r_hs1 && r_hp_cnt != H_MAX)
                r_hp_cnt <= r_hp_cnt + 12'd1;
            if (r_blank1 && r_ha_cnt != H_MAX)
                r_ha_cnt <= r_ha_cnt + 12'd1;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_v_cnt      <= '0;
            r_va_cnt     <= '0;
            r_frame_bad  <= 1'b0;
            meas_vtotal  <= '0;
            meas_vactive <= '0;
        end else if (w_vs_fall) begin
            meas_vtotal  <= w_vtot_close;
            meas_vactive <= w_vact_close;
            r_v_cnt      <= '0;
            r_va_cnt     <= '0;
            r_frame_bad  <= 1'b0;
        end else if (w_hs_fall) begin
            r_v_cnt  <= w_vtot_close;
            r_va_cnt <= w_vact_close;
            if (w_line_bad)
                r_frame_bad <= 1'b1;
        end
    end

    // Loss-of-signal timer: reloads on every HS fall, fires once when it runs out
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_los_cnt   <= '0;
            r_los_armed <= 1'b0;
        end else if (w_hs_fall) begin
            r_los_cnt   <= LOS_LOAD;
            r_los_armed <= 1'b1;
        end else begin
            if (r_los_cnt != '0)
                r_los_cnt <= r_los_cnt - 12'd1;
            if (w_los)
                r_los_armed <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_err_inc   = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_vs_fall) begin
                    w_state_nxt = MEASURE;
                    w_good_nxt  = '0;
                end
            end
            MEASURE: begin
                if (w_los) begin
                    w_state_nxt = SEARCH;
                    w_good_nxt  = '0;
                    w_err_inc   = 1'b1;
                end else if (w_vs_fall) begin
                    if (w_frame_ok) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc >= P_LOCK)
                            w_state_nxt = LOCKED;
                    end else begin
                        w_good_nxt = '0;
                        w_err_inc  = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (w_los) begin
                    w_state_nxt = SEARCH;
                    w_good_nxt  = '0;
                    w_err_inc   = 1'b1;
                end else if (w_vs_fall && !w_frame_ok) begin
                    w_state_nxt = MEASURE;
                    w_good_nxt  = '0;
                    w_err_inc   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
                w_good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_state   <= SEARCH;
            r_good    <= '0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
            locked  <= (w_state_nxt == LOCKED);
            if (w_err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

`ifdef VIDEO_MON_CHECKSUM_EN
    logic [23:0] r_rgb1;
    logic [31:0] r_acc;
    logic [9:0]  w_pix_sum;
    logic [31:0] w_pix_add;

    assign w_pix_sum = {2'b00, r_rgb1[23:16]} + {2'b00, r_rgb1[15:8]} + {2'b00, r_rgb1[7:0]};
    assign w_pix_add = r_blank1 ? {22'd0, w_pix_sum} : 32'd0;

    // The pixel seen in the VS-fall cycle starts the new frame's sum
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_rgb1    <= '0;
            r_acc     <= '0;
            frame_sum <= '0;
        end else begin
            r_rgb1 <= rgb;
            if (w_vs_fall) begin
                frame_sum <= r_acc;
                r_acc     <= w_pix_add;
            end else begin
                r_acc <= r_acc + w_pix_add;
            end
        end
    end
`else
    logic w_rgb_unused;
    assign w_rgb_unused = ^rgb;
`endif

endmodule

// File: tb/tb_video_timing_monitor.sv
// Randomized self-checking bench for video_timing_monitor against a sample-level reference model.
// Uses a reduced geometry so full frames stay short; set VIDEO_MON_CHECKSUM_EN to cover frame_sum.
module tb_video_timing_monitor;

    localparam int HD = 16, VD = 6, HT = 28, HP = 4, VT = 10, LF = 2;
    localparam int ACT_C0 = 8, ACT_L0 = 3;
    localparam int M_SEARCH = 0, M_MEASURE = 1, M_LOCKED = 2;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst = 1'b1;
    logic        hs = 1'b0, vs = 1'b0, blank = 1'b0;
    logic [23:0] rgb = '0;
    logic        line_start, frame_start, locked;
    logic [11:0] meas_htotal, meas_hpulse, meas_hactive;
    logic [10:0] meas_vtotal, meas_vactive;
    logic [7:0]  err_count;
`ifdef VIDEO_MON_CHECKSUM_EN
    logic [31:0] frame_sum;
`endif

    video_timing_monitor #(
        .HDISP(HD), .VDISP(VD), .HTOTAL(HT), .HPULSE(HP), .VTOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
        .hs(hs), .vs(vs), .blank(blank), .rgb(rgb),
        .line_start(line_start), .frame_start(frame_start), .locked(locked),
        .meas_htotal(meas_htotal), .meas_hpulse(meas_hpulse), .meas_hactive(meas_hactive),
        .meas_vtotal(meas_vtotal), .meas_vactive(meas_vactive), .err_count(err_count)
`ifdef VIDEO_MON_CHECKSUM_EN
        , .frame_sum(frame_sum)
`endif
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one call per input sample, expected outputs queued two samples deep
    typedef struct {
        bit ls; bit fs; bit lk;
        int ht; int hp; int ha; int vt; int va; int err;
        longint sum;
    } exp_t;
    exp_t q[$];

    bit     m_prev_hs, m_prev_vs, m_fbad;
    int     m_lt, m_lo, m_la, m_fl, m_fa, m_mode, m_good, m_since, m_err;
    int     o_ht, o_hp, o_ha, o_vt, o_va;
    longint m_acc, o_sum;

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_sample(input bit h, input bit v, input bit b, input logic [23:0] c);
        bit hf, vf, lbad, los, ok;
        exp_t e;
        hf = m_prev_hs && !h;
        vf = m_prev_vs && !v;
        los = 1'b0;
        if (hf) begin
            o_ht = m_lt; o_hp = m_lo; o_ha = m_la;
            lbad = (m_lt != HT) || (m_lo != HP) || (m_la != 0 && m_la != HD)
                || m_lt == 4095 || m_lo == 4095 || m_la == 4095;
            m_fl = sat(m_fl + 1, 2047);
            if (m_la != 0) m_fa = sat(m_fa + 1, 2047);
            if (lbad) m_fbad = 1'b1;
            m_lt = 0; m_lo = 0; m_la = 0;
            m_since = 0;
        end else if (m_since >= 0) begin
            m_since++;
        end
        if (m_since == 4096 && m_mode != M_SEARCH) begin
            los = 1'b1; m_mode = M_SEARCH; m_good = 0; m_err = sat(m_err + 1, 255);
        end
        if (vf) begin
            ok = !m_fbad && m_fl == VT && m_fa == VD;
            o_vt = m_fl; o_va = m_fa;
            m_fl = 0; m_fa = 0; m_fbad = 1'b0;
            o_sum = m_acc; m_acc = 0;
            if (!los) begin
                if (m_mode == M_SEARCH) begin
                    m_mode = M_MEASURE; m_good = 0;
                end else if (ok) begin
                    if (m_mode == M_MEASURE) begin
                        m_good++;
                        if (m_good >= LF) m_mode = M_LOCKED;
                    end
                end else begin
                    m_mode = M_MEASURE; m_good = 0; m_err = sat(m_err + 1, 255);
                end
            end
        end
        m_lt = sat(m_lt + 1, 4095);
        if (!h) m_lo = sat(m_lo + 1, 4095);
        if (b) begin
            m_la = sat(m_la + 1, 4095);
            m_acc = (m_acc + c[23:16] + c[15:8] + c[7:0]) % 64'h1_0000_0000;
        end
        m_prev_hs = h; m_prev_vs = v;
        e.ls = hf; e.fs = vf; e.lk = (m_mode == M_LOCKED);
        e.ht = o_ht; e.hp = o_hp; e.ha = o_ha; e.vt = o_vt; e.va = o_va;
        e.err = m_err; e.sum = o_sum;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_prev_hs = 0; m_prev_vs = 0; m_fbad = 0;
        m_lt = 0; m_lo = 0; m_la = 0; m_fl = 0; m_fa = 0;
        m_mode = M_SEARCH; m_good = 0; m_since = -1; m_err = 0;
        o_ht = 0; o_hp = 0; o_ha = 0; o_vt = 0; o_va = 0;
        m_acc = 0; o_sum = 0;
        model_sample(1'b0, 1'b0, 1'b0, 24'd0);  // the cycle the input stage still holds reset zeros
    endtask

    exp_t ce;
    always @(negedge pixel_clk) begin
        if (!pixel_rst && q.size() >= 3) begin
            ce = q.pop_front();
            chk("line_start", line_start, ce.ls);
            chk("frame_start", frame_start, ce.fs);
            chk("locked", locked, ce.lk);
            chk("meas_htotal", meas_htotal, ce.ht);
            chk("meas_hpulse", meas_hpulse, ce.hp);
            chk("meas_hactive", meas_hactive, ce.ha);
            chk("meas_vtotal", meas_vtotal, ce.vt);
            chk("meas_vactive", meas_vactive, ce.va);
            chk("err_count", err_count, ce.err);
`ifdef VIDEO_MON_CHECKSUM_EN
            chk("frame_sum", frame_sum, ce.sum);
`endif
        end
    end

    task automatic step(input bit h, input bit v, input bit b, input logic [23:0] c);
        hs = h; vs = v; blank = b; rgb = c;
        model_sample(h, v, b, c);
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 24'($urandom));
    endtask

    int f_ht, f_ha, f_vt, f_va, f_bad_line, f_vofs, f_lines;
    bit f_fixrgb, f_chk_pulse;

    task automatic nominal();
        f_ht = HT; f_ha = HD; f_vt = VT; f_va = VD; f_bad_line = -1;
        f_vofs = 0; f_lines = VT; f_fixrgb = 1'b0; f_chk_pulse = 1'b0;
    endtask

    task automatic send_frame();
        for (int l = 0; l < f_lines; l++) begin
            int  hpl;
            bit  act;
            hpl = (l == f_bad_line) ? HP - 1 : HP;
            act = (l >= ACT_L0) && (l < ACT_L0 + f_va);
            for (int c = 0; c < f_ht; c++) begin
                bit h, v, b;
                h = (c >= hpl);
                v = (l == 0) ? (c < f_vofs) : (l == 1) ? 1'b0 : (l == 2) ? (c >= f_vofs) : 1'b1;
                b = act && (c >= ACT_C0) && (c < ACT_C0 + f_ha);
                step(h, v, b, (b && f_fixrgb) ? 24'h010203 : 24'($urandom));
                if (f_chk_pulse && l == 0 && c == 1) begin
                    chk("coincident line_start", line_start, 1);
                    chk("coincident frame_start", frame_start, 1);
                end
                if (f_chk_pulse && l == 0 && c == 2) begin
                    chk("line_start one cycle", line_start, 0);
                    chk("frame_start one cycle", frame_start, 0);
                end
            end
        end
    endtask

    task automatic check_all_zero();
        chk("rst line_start", line_start, 0);
        chk("rst frame_start", frame_start, 0);
        chk("rst locked", locked, 0);
        chk("rst meas_htotal", meas_htotal, 0);
        chk("rst meas_hpulse", meas_hpulse, 0);
        chk("rst meas_hactive", meas_hactive, 0);
        chk("rst meas_vtotal", meas_vtotal, 0);
        chk("rst meas_vactive", meas_vactive, 0);
        chk("rst err_count", err_count, 0);
`ifdef VIDEO_MON_CHECKSUM_EN
        chk("rst frame_sum", frame_sum, 0);
`endif
    endtask

    task automatic apply_reset(input int ncyc);
        pixel_rst = 1'b1;
        #1;
        check_all_zero();
        q.delete();
        repeat (ncyc) @(posedge pixel_clk);
        #1;
        pixel_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by t=%0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        @(posedge pixel_clk);
        #1;
        apply_reset(3);
        idle(5);

        // nominal stream: lock at the second VS fall after the first
        nominal(); f_fixrgb = 1'b1;
        send_frame();
        f_chk_pulse = 1'b1; send_frame(); f_chk_pulse = 1'b0;
        chk("locked before 3rd vs fall", locked, 0);
        send_frame();
        chk("locked after 3rd vs fall", locked, 1);
        chk("pin meas_htotal", meas_htotal, 28);
        chk("pin meas_hpulse", meas_hpulse, 4);
        chk("pin meas_hactive", meas_hactive, 16);
        chk("pin meas_vtotal", meas_vtotal, 10);
        chk("pin meas_vactive", meas_vactive, 6);
        chk("pin err_count nominal", err_count, 0);
`ifdef VIDEO_MON_CHECKSUM_EN
        chk("pin frame_sum", frame_sum, 6 * HD * VD);
`endif
        nominal(); send_frame();

        // one short HS pulse while locked, then relock
        nominal(); f_bad_line = 4; send_frame();
        nominal(); send_frame();
        chk("pin locked after bad line", locked, 0);
        chk("pin err_count after bad line", err_count, 1);
        send_frame(); send_frame();
        chk("pin relocked", locked, 1);

        // loss of signal while locked
        idle(4100);
        chk("pin locked after los", locked, 0);
        chk("pin err_count after los", err_count, 2);
        chk("pin meas_htotal held", meas_htotal, 28);
        chk("pin meas_hactive held", meas_hactive, 16);
        chk("pin meas_vtotal held", meas_vtotal, 10);
        nominal(); send_frame(); send_frame();

        // randomized geometry perturbations
        for (int i = 0; i < 14; i++) begin
            nominal();
            case ($urandom_range(0, 7))
                2: f_ht = ($urandom_range(0, 1) != 0) ? HT + 1 : HT - 1;
                3: f_bad_line = $urandom_range(0, VT - 1);
                4: f_ha = HD + 1;
                5: f_vt = VT + 1;
                6: f_va = VD - 1;
                default: ;
            endcase
            f_vofs  = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 20);
            f_lines = f_vt;
            send_frame();
        end

        // reset in the middle of a locked frame
        nominal(); send_frame(); send_frame(); send_frame();
        f_lines = 5; send_frame();
        chk("pin locked before mid reset", locked, 1);
        apply_reset(3);
        idle(5);
        nominal(); send_frame(); send_frame();
        chk("pin locked after 2 vs falls post reset", locked, 0);
        send_frame();
        chk("pin locked after 3 vs falls post reset", locked, 1);
        chk("pin err_count post reset", err_count, 0);
        send_frame();
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
